imem_loader: RTL and testbench

- Writer side of the instruction-memory interface; the processor is the reader.
- Accepts a byte stream (valid/ready) from a host link, assembles 32-bit instruction words, and issues single-cycle writes to the imem write port.
- Holds the processor in reset until the image is fully loaded.
- Sits beside imem in the top level and runs on the imem clock domain.

---
 rtl/imem_loader_pkg.sv | 26 ++
 rtl/imem_loader_word_assembler.sv | 43 ++++
 rtl/imem_loader.sv | 201 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_pkg
// Purpose  : Shared types and constants for the imem loader:
//            - the loader state encoding
//            - the fixed bytes-per-word value
//            - the width of the frame word-count header
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int COUNT_WIDTH    = 16;

  typedef enum logic [2:0] {
    ST_HDR_HI = 3'd0,
    ST_HDR_LO = 3'd1,
    ST_DATA   = 3'd2,
    ST_CSUM   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : word_assembler
// Purpose  : Packs four MSB-first stream bytes into one 32-bit instruction word.
// Ports    : clock      - rising-edge clock
//            clear      - synchronous clear of byte counter and shift register
//            shift_en   - a byte is accepted this cycle
//            byte_in    - stream byte
//            word       - assembled word (valid while word_valid is high)
//            word_valid - high in the cycle the 4th byte of a word is accepted
// Revision : 1.0 - initial release
// ============================================================================
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  byte_count;
  // Only the first three bytes need storage; the 4th byte is taken straight
  // from byte_in so the full word is available in the cycle it arrives.
  logic [23:0] shift_reg;

  always_ff @(posedge clock) begin
    if (clear) begin
      byte_count <= 2'd0;
      shift_reg  <= 24'd0;
    end else if (shift_en) begin
      byte_count <= byte_count + 2'd1;
      shift_reg  <= {shift_reg[15:0], byte_in};
    end
  end

  assign word       = {shift_reg, byte_in};
  assign word_valid = shift_en && (byte_count == 2'(BYTES_PER_WORD - 1));

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Writer side of the instruction memory. Receives a framed byte
//            stream (16-bit word count, high byte first, then the words MSB
//            first), writes each word into imem and holds the processor in
//            reset until the image is complete.
//            Optional macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR
//            checksum byte that must match for the load to succeed.
// Ports    : clock, reset          - clock / synchronous active-high reset
//            start                 - re-arm pulse (honoured in DONE / ERR only)
//            byte_in, byte_valid   - stream input
//            byte_ready            - loader can accept a byte
//            wr_address, wr_data   - imem write port address / data
//            wr_en                 - one-cycle write strobe per word
//            hold_processor        - processor reset while loading
//            done, error           - load status levels
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,   // fixed: four bytes per word
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic [ADDR_WIDTH-1:0] wr_address,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_en,
  output logic                  hold_processor,
  output logic                  done,
  output logic                  error
);

  // Word counts are compared in a width wide enough for both the 16-bit
  // header and 2^ADDR_WIDTH.
  localparam int          CMP_WIDTH = 33;
  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_WIDTH;

  state_t                 state;
  state_t                 state_next;
  logic [7:0]             count_hi;
  logic [COUNT_WIDTH-1:0] word_count;
  logic [ADDR_WIDTH-1:0]  index;

  logic                   accept;
  logic                   rearm;
  logic                   clear;
  logic                   data_shift;
  logic                   word_valid;
  logic [31:0]            word;
  logic [CMP_WIDTH-1:0]   hdr_count;
  logic                   last_word;
  logic                   too_big;

  assign accept     = byte_valid && byte_ready;
  assign rearm      = start && (state == ST_DONE || state == ST_ERR);
  assign clear      = reset || rearm;
  assign data_shift = accept && (state == ST_DATA);
  assign hdr_count  = CMP_WIDTH'({count_hi, byte_in});
  assign too_big    = hdr_count > MAX_WORDS;
  assign last_word  = (CMP_WIDTH'(index) + 33'd1) == CMP_WIDTH'(word_count);

  word_assembler u_word_assembler (
    .clock      (clock),
    .clear      (clear),
    .shift_en   (data_shift),
    .byte_in    (byte_in),
    .word       (word),
    .word_valid (word_valid)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR of every header and data byte; the CSUM byte must equal it.
  logic [7:0] csum;

  always_ff @(posedge clock) begin
    if (clear) begin
      csum <= 8'd0;
    end else if (accept && state != ST_CSUM) begin
      csum <= csum ^ byte_in;
    end
  end
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_HDR_HI;
    end else begin
      state <= state_next;
    end
  end

  // Next state and status outputs. byte_ready is 1 in every accepting state,
  // so byte_valid alone stands for a transfer here (reset overrides it).
  always_comb begin
    state_next     = state;
    byte_ready     = 1'b0;
    done           = 1'b0;
    error          = 1'b0;
    hold_processor = 1'b1;
    case (state)
      ST_HDR_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          state_next = ST_HDR_LO;
        end
      end
      ST_HDR_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          if (hdr_count == '0) begin
            state_next = ST_DONE;
          end else if (too_big) begin
            state_next = ST_ERR;
          end else begin
            state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        byte_ready = 1'b1;
        if (word_valid && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_next = ST_CSUM;
`else
          state_next = ST_DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          state_next = (byte_in == csum) ? ST_DONE : ST_ERR;
        end
      end
`endif
      ST_DONE: begin
        done           = 1'b1;
        hold_processor = 1'b0;
        if (start) begin
          state_next = ST_HDR_HI;
        end
      end
      ST_ERR: begin
        error = 1'b1;
        if (start) begin
          state_next = ST_HDR_HI;
        end
      end
      default: begin
        state_next = ST_HDR_HI;
      end
    endcase
    // The status levels read as their reset values during the reset cycle.
    if (reset) begin
      byte_ready     = 1'b0;
      done           = 1'b0;
      error          = 1'b0;
      hold_processor = 1'b1;
    end
  end

  // Header capture and registered imem write port
  always_ff @(posedge clock) begin
    if (reset) begin
      count_hi   <= 8'd0;
      word_count <= '0;
      index      <= '0;
      wr_en      <= 1'b0;
      wr_address <= ADDR_WIDTH'(BASE_ADDR);
      wr_data    <= '0;
    end else begin
      wr_en <= 1'b0;
      if (accept && state == ST_HDR_HI) begin
        count_hi <= byte_in;
      end
      if (accept && state == ST_HDR_LO) begin
        word_count <= {count_hi, byte_in};
        index      <= '0;
      end
      if (word_valid) begin
        wr_en      <= 1'b1;
        wr_data    <= word;
        // Address wraps naturally in ADDR_WIDTH bits.
        wr_address <= ADDR_WIDTH'(BASE_ADDR) + index;
        index      <= index + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Self-checking bench for imem_loader. Two instances share the
//            stream: one at BASE_ADDR=0 and one at BASE_ADDR=4094 to exercise
//            address wrap. Expected writes are queued per instance and popped
//            as wr_en pulses appear. Honours IMEM_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;

  logic        byte_ready0, wr_en0, hold0, done0, error0;
  logic [11:0] wr_address0;
  logic [31:0] wr_data0;
  logic        byte_ready1, wr_en1, hold1, done1, error1;
  logic [11:0] wr_address1;
  logic [31:0] wr_data1;

  int checks = 0;
  int errors = 0;

  logic [43:0] exp0[$];
  logic [43:0] exp1[$];

  imem_loader #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .BASE_ADDR(0)) dut0 (
    .clock(clock), .reset(reset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready0), .wr_address(wr_address0),
    .wr_data(wr_data0), .wr_en(wr_en0), .hold_processor(hold0), .done(done0),
    .error(error0)
  );

  imem_loader #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .BASE_ADDR(4094)) dut1 (
    .clock(clock), .reset(reset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready1), .wr_address(wr_address1),
    .wr_data(wr_data1), .wr_en(wr_en1), .hold_processor(hold1), .done(done1),
    .error(error1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard: every wr_en pulse must match the head of its queue.
  always @(negedge clock) begin
    if (wr_en0) begin
      checks++;
      if (exp0.size() == 0) begin
        errors++;
        $display("FAIL write0_unexpected got addr=%h data=%h, required none", wr_address0, wr_data0);
      end else begin
        logic [43:0] e0;
        e0 = exp0.pop_front();
        if ({wr_address0, wr_data0} !== e0) begin
          errors++;
          $display("FAIL write0 got addr=%h data=%h, required addr=%h data=%h",
                   wr_address0, wr_data0, e0[43:32], e0[31:0]);
        end
      end
    end
    if (wr_en1) begin
      checks++;
      if (exp1.size() == 0) begin
        errors++;
        $display("FAIL write1_unexpected got addr=%h data=%h, required none", wr_address1, wr_data1);
      end else begin
        logic [43:0] e1;
        e1 = exp1.pop_front();
        if ({wr_address1, wr_data1} !== e1) begin
          errors++;
          $display("FAIL write1 got addr=%h data=%h, required addr=%h data=%h",
                   wr_address1, wr_data1, e1[43:32], e1[31:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got running, required finished");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  function automatic void push_expect(input logic [31:0] w[$]);
    for (int i = 0; i < w.size(); i++) begin
      exp0.push_back({12'(i), w[i]});
      exp1.push_back({12'(4094 + i), w[i]});
    end
  endfunction

  task automatic build(input logic [31:0] w[$], output logic [7:0] bq[$]);
    logic [15:0] n;
    logic [7:0]  x;
    n  = 16'(w.size());
    bq = {};
    bq.push_back(n[15:8]);
    bq.push_back(n[7:0]);
    for (int i = 0; i < w.size(); i++) begin
      logic [31:0] wd;
      wd = w[i];
      bq.push_back(wd[31:24]);
      bq.push_back(wd[23:16]);
      bq.push_back(wd[15:8]);
      bq.push_back(wd[7:0]);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (w.size() > 0) begin
      x = 8'd0;
      foreach (bq[i]) x = x ^ bq[i];
      bq.push_back(x);
    end
`else
    x = 8'd0;
`endif
  endtask

  // Present each byte until a handshake; optional random idle gaps.
  task automatic send_bytes(input logic [7:0] bq[$], input bit rnd);
    for (int i = 0; i < bq.size(); i++) begin
      int  budget;
      bit  got;
      if (rnd) begin
        int g;
        g = $urandom_range(0, 2);
        byte_valid = 1'b0;
        repeat (g) step();
      end
      byte_in    = bq[i];
      byte_valid = 1'b1;
      budget     = 0;
      got        = 1'b0;
      while (!got && budget < 20) begin
        @(negedge clock);
        got = byte_ready0;
        step();
        budget++;
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL send_byte idx=%0d got ready=0, required ready=1", i);
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic check_queues_empty(input string name);
    checks++;
    if (exp0.size() != 0 || exp1.size() != 0) begin
      errors++;
      $display("FAIL %s_pending got %0d/%0d outstanding writes, required 0/0",
               name, exp0.size(), exp1.size());
    end
  endtask

  task automatic rearm(input string name);
    start = 1'b1;
    step();
    start = 1'b0;
    @(negedge clock);
    checks++;
    if ({byte_ready0, hold0, done0, error0} !== 4'b1100) begin
      errors++;
      $display("FAIL %s_rearm got ready/hold/done/err=%b, required 1100",
               name, {byte_ready0, hold0, done0, error0});
    end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({byte_ready0, wr_en0, hold0, done0, error0} !== 5'b00100) begin
      errors++;
      $display("FAIL reset_flags got ready/wr/hold/done/err=%b, required 00100",
               {byte_ready0, wr_en0, hold0, done0, error0});
    end
    checks++;
    if (wr_address0 !== 12'd0 || wr_data0 !== 32'd0 || wr_address1 !== 12'd4094) begin
      errors++;
      $display("FAIL reset_port got addr0=%h data0=%h addr1=%h, required 000 00000000 ffe",
               wr_address0, wr_data0, wr_address1);
    end
    step();
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (byte_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b, required 1", byte_ready0);
    end
    step();
  endtask

  task automatic test_two_words(input bit rnd, input string name);
    logic [31:0] w[$];
    logic [7:0]  bq[$];
    w = {32'hDEADBEEF, 32'h01234567};
    build(w, bq);
    push_expect(w);
    send_bytes(bq, rnd);
`ifdef IMEM_LOADER_CHECKSUM_EN
    @(negedge clock);
    checks++;
    if ({done0, hold0} !== 2'b10) begin
      errors++;
      $display("FAIL %s_done got done/hold=%b, required 10", name, {done0, hold0});
    end
`else
    // The last write and the first DONE cycle coincide.
    @(negedge clock);
    checks++;
    if ({wr_en0, done0, hold0} !== 3'b110) begin
      errors++;
      $display("FAIL %s_last_write got wr/done/hold=%b, required 110", name, {wr_en0, done0, hold0});
    end
`endif
    step();
    idle(2);
    check_queues_empty(name);
    @(negedge clock);
    checks++;
    if ({done0, byte_ready0} !== 2'b10) begin
      errors++;
      $display("FAIL %s_done_level got done/ready=%b, required 10", name, {done0, byte_ready0});
    end
    step();
    rearm(name);
  endtask

  task automatic test_empty_frame();
    logic [7:0] bq[$];
    bit got;
    bq = {8'h00, 8'h00};
    send_bytes(bq, 1'b0);
    got = 1'b0;
    for (int k = 0; k < 3 && !got; k++) begin
      @(negedge clock);
      got = done0;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL empty_done got done=0, required 1");
    end
    step();
    idle(3);
    check_queues_empty("empty");
    rearm("empty");
  endtask

  task automatic test_too_big();
    logic [7:0] bq[$];
    bq = {8'h10, 8'h01};
    send_bytes(bq, 1'b0);
    @(negedge clock);
    checks++;
    if ({error0, hold0, byte_ready0, done0} !== 4'b1100) begin
      errors++;
      $display("FAIL too_big got err/hold/ready/done=%b, required 1100",
               {error0, hold0, byte_ready0, done0});
    end
    step();
    idle(4);
    check_queues_empty("too_big");
    rearm("too_big");
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] w[$];
    logic [7:0]  bq[$];
    logic [7:0]  part[$];
    w = {32'hDEADBEEF, 32'h01234567};
    build(w, bq);
    part = bq[0:7];
    push_expect({32'hDEADBEEF});
    send_bytes(part, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({byte_ready0, hold0, done0, error0} !== 4'b1100) begin
      errors++;
      $display("FAIL midreset_state got ready/hold/done/err=%b, required 1100",
               {byte_ready0, hold0, done0, error0});
    end
    step();
    idle(5);
    check_queues_empty("midreset");
    // A fresh frame must not pick up the discarded partial word.
    w = {32'hCAFEF00D};
    build(w, bq);
    push_expect(w);
    send_bytes(bq, 1'b0);
    idle(3);
    check_queues_empty("after_midreset");
    rearm("after_midreset");
  endtask

  task automatic test_addr_wrap();
    logic [31:0] w[$];
    logic [7:0]  bq[$];
    w = {32'h11111111, 32'h22222222, 32'h33333333};
    build(w, bq);
    push_expect(w);   // instance at 4094 expects 4094, 4095, 000
    send_bytes(bq, 1'b0);
    idle(3);
    check_queues_empty("wrap");
    rearm("wrap");
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] bq[$];
    bq = {8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    push_expect({32'h11223344});
    send_bytes(bq, 1'b0);
    @(negedge clock);
    checks++;
    if ({done0, error0, hold0} !== 3'b100) begin
      errors++;
      $display("FAIL csum_good got done/err/hold=%b, required 100", {done0, error0, hold0});
    end
    step();
    check_queues_empty("csum_good");
    rearm("csum_good");
    bq = {8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    push_expect({32'h11223344});
    send_bytes(bq, 1'b0);
    @(negedge clock);
    checks++;
    if ({done0, error0, hold0} !== 3'b011) begin
      errors++;
      $display("FAIL csum_bad got done/err/hold=%b, required 011", {done0, error0, hold0});
    end
    step();
    check_queues_empty("csum_bad");
    rearm("csum_bad");
  endtask
`endif

  initial begin
    test_reset();
    test_two_words(1'b0, "two_words");
    test_empty_frame();
    test_too_big();
    test_two_words(1'b1, "random_valid");
    test_reset_mid_load();
    test_addr_wrap();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
